// File: rtl/register_file_mp_if.sv
// Register file access bundle: two write ports, packed read ports,
// and the sequential-clear handshake.
interface register_file_mp_if #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2
);
  logic                   we0;
  logic [AW-1:0]          wa0;
  logic [XLEN-1:0]        wd0;
  logic                   we1;
  logic [AW-1:0]          wa1;
  logic [XLEN-1:0]        wd1;
  logic [NUM_RD*AW-1:0]   ra;
  logic [NUM_RD*XLEN-1:0] rd;
  logic                   clr_req;
  logic                   clr_busy;
  logic                   clr_done;

  modport master (
    output we0, wa0, wd0,
    output we1, wa1, wd1,
    output ra, clr_req,
    input  rd, clr_busy, clr_done
  );

  modport slave (
    input  we0, wa0, wd0,
    input  we1, wa1, wd1,
    input  ra, clr_req,
    output rd, clr_busy, clr_done
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file with 2 write ports, N combinational read
// ports, optional x0 hardwiring, write bypass and a sequential clear.
module register_file_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  register_file_mp_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      r_state;
  logic [AW-1:0]   r_ptr;
  logic [XLEN-1:0] r_mem [NUM_REGS];

  logic                   w_busy;
  logic                   w_we0;
  logic                   w_we1;
  logic [NUM_RD*XLEN-1:0] w_rd;

  // In range and not the hardwired zero register
  function automatic logic f_ok(input logic [AW-1:0] a);
    return (int'(a) < NUM_REGS) && !(ZERO_REG != 0 && a == '0);
  endfunction

  assign w_busy = (r_state != S_IDLE);
  assign w_we0  = bus.we0 && !w_busy && f_ok(bus.wa0);
  assign w_we1  = bus.we1 && !w_busy && f_ok(bus.wa1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.clr_req) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
          end
        end
        S_CLEAR: begin
          r_ptr <= r_ptr + AW'(1);
          if (r_ptr == AW'(NUM_REGS - 1))
            r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Port 1 wins a same-address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_state == S_CLEAR && r_ptr == AW'(i))
          r_mem[i] <= '0;
        else if (w_we1 && bus.wa1 == AW'(i))
          r_mem[i] <= bus.wd1;
        else if (w_we0 && bus.wa0 == AW'(i))
          r_mem[i] <= bus.wd0;
      end
    end
  end

  function automatic logic [XLEN-1:0] f_read(
    input logic [AW-1:0] a
  );
    if (!f_ok(a))
      return '0;
    if (BYPASS != 0 && w_we1 && bus.wa1 == a)
      return bus.wd1;
    if (BYPASS != 0 && w_we0 && bus.wa0 == a)
      return bus.wd0;
    return r_mem[a];
  endfunction

  always_comb begin
    w_rd = '0;
    for (int k = 0; k < NUM_RD; k++)
      w_rd[k*XLEN +: XLEN] = f_read(bus.ra[k*AW +: AW]);
  end

  assign bus.rd       = w_rd;
  assign bus.clr_busy = w_busy;
  assign bus.clr_done = (r_state == S_DONE);
endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed table, random
// traffic against an array model, clear/reset corner sequences.
module tb_register_file_mp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_mp_if #(.XLEN(32), .AW(5), .NUM_RD(2)) bus ();
  register_file_mp_if #(.XLEN(32), .AW(5), .NUM_RD(2)) bus24 ();

  register_file_mp #(
    .XLEN(32), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
  ) u_dut (.clk(clk), .rst(rst), .bus(bus));

  register_file_mp #(
    .XLEN(32), .NUM_REGS(24), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
  ) u_dut24 (.clk(clk), .rst(rst), .bus(bus24));

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] model [32];
  int          checks = 0;
  int          failures = 0;
  int          n;
  int          dn;
  logic [4:0]  a0;
  logic [4:0]  a1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic we0, input logic [4:0] wa0,
                     input logic [31:0] wd0, input logic we1,
                     input logic [4:0] wa1, input logic [31:0] wd1,
                     input logic [4:0] ra0, input logic [4:0] ra1);
    bus.we0 = we0; bus.wa0 = wa0; bus.wd0 = wd0;
    bus.we1 = we1; bus.wa1 = wa1; bus.wd1 = wd1;
    bus.ra  = {ra1, ra0};
  endtask

  task automatic idle24();
    bus24.we0 = 1'b0; bus24.wa0 = '0; bus24.wd0 = '0;
    bus24.we1 = 1'b0; bus24.wa1 = '0; bus24.wd1 = '0;
    bus24.ra  = '0;   bus24.clr_req = 1'b0;
  endtask

  // Expected read: x0 is zero, then same-cycle write (port 1 first), else stored
  function automatic logic [31:0] m_exp(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (bus.we1 && bus.wa1 == a) return bus.wd1;
    if (bus.we0 && bus.wa0 == a) return bus.wd0;
    return model[a];
  endfunction

  task automatic m_commit();
    if (bus.we0 && bus.wa0 != 5'd0) model[bus.wa0] = bus.wd0;
    if (bus.we1 && bus.wa1 != 5'd0) model[bus.wa1] = bus.wd1;
  endtask

  task automatic step(input string nm);
    #3;
    chk({nm, "_rd0"}, bus.rd[31:0], m_exp(bus.ra[4:0]));
    chk({nm, "_rd1"}, bus.rd[63:32], m_exp(bus.ra[9:5]));
    @(posedge clk);
    m_commit();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
               5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222,
               5'd7, 5'd5, 32'h22222222, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               5'd7, 5'd7, 32'h22222222, 32'h22222222};
    tbl[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,
               5'd0, 5'd0, 32'h0, 32'h0};
    tbl[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               5'd0, 5'd5, 32'h0, 32'hDEADBEEF};
    tbl[6] = '{1'b1, 5'd4, 32'h12345678, 1'b1, 5'd3, 32'hA5A5A5A5,
               5'd3, 5'd4, 32'hA5A5A5A5, 32'h12345678};
    tbl[7] = '{1'b1, 5'd3, 32'h0BADF00D, 1'b0, 5'd0, 32'h0,
               5'd3, 5'd31, 32'h0BADF00D, 32'h0};
    tbl[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               5'd3, 5'd4, 32'h0BADF00D, 32'h12345678};
    tbl[9] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'hCAFEBABE,
               5'd31, 5'd30, 32'hCAFEBABE, 32'h0};
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    rst = 1'b1;
    bus.clr_req = 1'b0;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    idle24();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd0", bus.rd[31:0], 32'h0);
    chk("reset_rd1", bus.rd[63:32], 32'h0);
    chk("reset_busy", {31'h0, bus.clr_busy}, 32'h0);
    chk("reset_done", {31'h0, bus.clr_done}, 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      drv(tbl[v].we0, tbl[v].wa0, tbl[v].wd0, tbl[v].we1, tbl[v].wa1,
          tbl[v].wd1, tbl[v].ra0, tbl[v].ra1);
      #3;
      chk($sformatf("vec%0d_rd0", v), bus.rd[31:0], tbl[v].e0);
      chk($sformatf("vec%0d_rd1", v), bus.rd[63:32], tbl[v].e1);
      @(posedge clk);
      m_commit();
      #1;
    end

    for (int t = 0; t < 300; t++) begin
      a0 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
      drv(1'($urandom_range(0, 1)), a0, $urandom,
          1'($urandom_range(0, 1)), a1, $urandom,
          ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31)),
          ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 31)));
      step("rand");
    end

    for (int i = 1; i < 32; i++) begin
      drv(1'b1, 5'(i), 32'h10000000 | i, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      @(posedge clk);
      m_commit();
      #1;
    end
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd31);
    #1;
    chk("fill_x20", bus.rd[31:0], 32'h10000014);
    bus.clr_req = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_req = 1'b0;
    n = 0;
    dn = 0;
    while (bus.clr_busy && n < 100) begin
      n++;
      if (bus.clr_done) dn++;
      drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd20);
      if (n == 2) begin
        #1;
        chk("clear_read_live", bus.rd[63:32], 32'h10000014);
      end
      if (n == 12) begin
        drv(1'b1, 5'd3, 32'h77, 1'b0, 5'd0, 32'h0, 5'd3, 5'd20);
        #1;
        chk("clear_no_bypass", bus.rd[31:0], 32'h0);
      end
      @(posedge clk);
      #1;
    end
    chk("clear_busy_cycles", 32'(n), 32'd33);
    chk("clear_done_pulses", 32'(dn), 32'd1);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int a = 0; a < 32; a++) begin
      drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
      #1;
      chk($sformatf("cleared_x%0d", a), bus.rd[31:0], 32'h0);
    end

    bus.clr_req = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (bus.clr_busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("held_req_first_run", 32'(n), 32'd33);
    @(posedge clk);
    #1;
    chk("held_req_restart", {31'h0, bus.clr_busy}, 32'h1);
    bus.clr_req = 1'b0;
    n = 0;
    while (bus.clr_busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("held_req_second_end", {31'h0, bus.clr_busy}, 32'h0);

    bus24.we0 = 1'b1; bus24.wa0 = 5'd30; bus24.wd0 = 32'h30303030;
    bus24.we1 = 1'b1; bus24.wa1 = 5'd23; bus24.wd1 = 32'h23232323;
    bus24.ra  = {5'd23, 5'd30};
    #1;
    chk("r24_oob_bypass", bus24.rd[31:0], 32'h0);
    chk("r24_top_bypass", bus24.rd[63:32], 32'h23232323);
    @(posedge clk);
    #1;
    idle24();
    bus24.ra = {5'd23, 5'd30};
    #1;
    chk("r24_oob_read", bus24.rd[31:0], 32'h0);
    chk("r24_top_read", bus24.rd[63:32], 32'h23232323);
    bus24.clr_req = 1'b1;
    @(posedge clk);
    #1;
    bus24.clr_req = 1'b0;
    n = 0;
    while (bus24.clr_busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("r24_busy_cycles", 32'(n), 32'd25);

    for (int i = 1; i < 32; i++) begin
      drv(1'b1, 5'(i), 32'hA0000000 | i, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      @(posedge clk);
      #1;
    end
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd31);
    bus.clr_req = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_pre_x20", bus.rd[31:0], 32'hA0000014);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'h0, bus.clr_busy}, 32'h0);
    chk("abort_done", {31'h0, bus.clr_done}, 32'h0);
    chk("abort_x20", bus.rd[31:0], 32'h0);
    chk("abort_x31", bus.rd[63:32], 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drv(1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    @(posedge clk);
    #1;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    #1;
    chk("first_write_after_rst", bus.rd[31:0], 32'h99999999);
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.clr_done || bus.clr_busy) dn++;
      @(posedge clk);
      #1;
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
